// File: rtl/rob_wide_if.sv
// Decode/writeback/commit/lookup bundle of the wide reorder buffer.
// The master drives allocation, writeback and lookup addresses; the ROB is the slave.
interface rob_wide_if #(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int WB_PORTS     = 1
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                         alloc_valid_i;
    logic [31:0]                  alloc_pc_i;
    logic [31:0]                  alloc_instr_i;
    logic [4:0]                   alloc_rd_i;
    logic                         alloc_we_i;
    logic [IDX_W-1:0]             alloc_idx_o;
    logic                         full_o;
    logic                         empty_o;

    logic [WB_PORTS-1:0]          wb_valid_i;
    logic [WB_PORTS*IDX_W-1:0]    wb_idx_i;
    logic [WB_PORTS*32-1:0]       wb_result_i;
    logic [WB_PORTS-1:0]          wb_branch_taken_i;
    logic [WB_PORTS*32-1:0]       wb_new_pc_i;

    logic [COMMIT_WIDTH-1:0]      commit_valid_o;
    logic [COMMIT_WIDTH*32-1:0]   commit_pc_o;
    logic [COMMIT_WIDTH*32-1:0]   commit_instr_o;
    logic [COMMIT_WIDTH*32-1:0]   commit_result_o;
    logic [COMMIT_WIDTH*5-1:0]    commit_rd_o;
    logic [COMMIT_WIDTH-1:0]      commit_we_o;
    logic                         flush_o;
    logic [31:0]                  flush_pc_o;

    logic [4:0]                   rs1_addr_i;
    logic [4:0]                   rs2_addr_i;
    logic                         hazard_rs1_o;
    logic                         hazard_rs2_o;
    logic [IDX_W-1:0]             entry_rs1_o;
    logic [IDX_W-1:0]             entry_rs2_o;
    logic                         completed_rs1_o;
    logic                         completed_rs2_o;
    logic [31:0]                  result_rs1_o;
    logic [31:0]                  result_rs2_o;

    modport master (
        output alloc_valid_i, alloc_pc_i, alloc_instr_i, alloc_rd_i, alloc_we_i,
        output wb_valid_i, wb_idx_i, wb_result_i, wb_branch_taken_i, wb_new_pc_i,
        output rs1_addr_i, rs2_addr_i,
        input  alloc_idx_o, full_o, empty_o,
        input  commit_valid_o, commit_pc_o, commit_instr_o, commit_result_o, commit_rd_o, commit_we_o,
        input  flush_o, flush_pc_o,
        input  hazard_rs1_o, hazard_rs2_o, entry_rs1_o, entry_rs2_o,
        input  completed_rs1_o, completed_rs2_o, result_rs1_o, result_rs2_o
    );

    modport slave (
        input  alloc_valid_i, alloc_pc_i, alloc_instr_i, alloc_rd_i, alloc_we_i,
        input  wb_valid_i, wb_idx_i, wb_result_i, wb_branch_taken_i, wb_new_pc_i,
        input  rs1_addr_i, rs2_addr_i,
        output alloc_idx_o, full_o, empty_o,
        output commit_valid_o, commit_pc_o, commit_instr_o, commit_result_o, commit_rd_o, commit_we_o,
        output flush_o, flush_pc_o,
        output hazard_rs1_o, hazard_rs2_o, entry_rs1_o, entry_rs2_o,
        output completed_rs1_o, completed_rs2_o, result_rs1_o, result_rs2_o
    );
endinterface

// File: rtl/rob_wide.sv
// Circular reorder buffer: one alloc/cycle, WB_PORTS writebacks, up to COMMIT_WIDTH in-order retires.
// Define ROB_BYPASS_EN to forward same-cycle writebacks into the rs1/rs2 hazard lookup.
module rob_wide #(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int WB_PORTS     = 1
) (
    input logic        clk_i,
    input logic        rst_i,
    rob_wide_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t             head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, retire_cnt;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;

    logic [31:0]      pc_q [DEPTH], pc_d [DEPTH], instr_q [DEPTH], instr_d [DEPTH];
    logic [31:0]      result_q [DEPTH], result_d [DEPTH], npc_q [DEPTH], npc_d [DEPTH];
    logic [4:0]       rd_q [DEPTH], rd_d [DEPTH];
    logic [DEPTH-1:0] we_q, we_d, taken_q, taken_d;

    idx_t             slot_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] commit_valid;
    logic             flush, stop, alloc_acc, full;
    logic [31:0]      flush_pc;
    idx_t             wb_idx [WB_PORTS];

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) wb_idx[p] = bus.wb_idx_i[p*IDX_W +: IDX_W];
    end

    // Retire the longest completed run from head, stopping after the first taken branch.
    always_comb begin
        commit_valid = '0;
        retire_cnt   = '0;
        flush        = 1'b0;
        flush_pc     = '0;
        stop         = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot_idx[k] = head_q + idx_t'(k);
            if (!stop && valid_q[slot_idx[k]] && done_q[slot_idx[k]]) begin
                commit_valid[k] = 1'b1;
                retire_cnt      = retire_cnt + CNT_W'(1);
                if (taken_q[slot_idx[k]]) begin
                    flush    = 1'b1;
                    flush_pc = npc_q[slot_idx[k]];
                    stop     = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        bus.commit_valid_o  = commit_valid;
        bus.commit_pc_o     = '0;
        bus.commit_instr_o  = '0;
        bus.commit_result_o = '0;
        bus.commit_rd_o     = '0;
        bus.commit_we_o     = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            bus.commit_pc_o[k*32 +: 32]     = pc_q[slot_idx[k]];
            bus.commit_instr_o[k*32 +: 32]  = instr_q[slot_idx[k]];
            bus.commit_result_o[k*32 +: 32] = result_q[slot_idx[k]];
            bus.commit_rd_o[k*5 +: 5]       = rd_q[slot_idx[k]];
            bus.commit_we_o[k]              = we_q[slot_idx[k]];
        end
    end

    assign full            = (count_q == CNT_W'(DEPTH));
    assign alloc_acc       = bus.alloc_valid_i && !full;
    assign bus.full_o      = full;
    assign bus.empty_o     = (count_q == '0);
    assign bus.alloc_idx_o = tail_q;
    assign bus.flush_o     = flush;
    assign bus.flush_pc_o  = flush_pc;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        done_d   = done_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        result_d = result_q;
        npc_d    = npc_q;
        rd_d     = rd_q;
        we_d     = we_q;
        taken_d  = taken_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (commit_valid[k]) valid_d[slot_idx[k]] = 1'b0;
            // Ascending port order lets the higher port win on a shared index.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_valid_i[p] && valid_q[wb_idx[p]]) begin
                    done_d[wb_idx[p]]   = 1'b1;
                    result_d[wb_idx[p]] = bus.wb_result_i[p*32 +: 32];
                    npc_d[wb_idx[p]]    = bus.wb_new_pc_i[p*32 +: 32];
                    taken_d[wb_idx[p]]  = bus.wb_branch_taken_i[p];
                end
            end
            if (alloc_acc) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                pc_d[tail_q]    = bus.alloc_pc_i;
                instr_d[tail_q] = bus.alloc_instr_i;
                rd_d[tail_q]    = bus.alloc_rd_i;
                we_d[tail_q]    = bus.alloc_we_i;
                tail_d          = tail_q + idx_t'(1);
            end
            head_d  = head_q + idx_t'(retire_cnt);
            count_d = count_q + CNT_W'(alloc_acc) - retire_cnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pc_q     <= pc_d;
        instr_q  <= instr_d;
        result_q <= result_d;
        npc_q    <= npc_d;
        rd_q     <= rd_d;
        we_q     <= we_d;
        taken_q  <= taken_d;
    end

    logic [4:0]  src [2];
    logic        hz [2], cmp [2];
    idx_t        ent [2];
    logic [31:0] res [2];
    idx_t        li;

    // Scanning from head upward leaves the youngest matching producer in ent.
    always_comb begin
        src[0] = bus.rs1_addr_i;
        src[1] = bus.rs2_addr_i;
        li     = '0;
        for (int s = 0; s < 2; s++) begin
            hz[s]  = 1'b0;
            ent[s] = '0;
            cmp[s] = 1'b0;
            res[s] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                li = head_q + idx_t'(i);
                if (src[s] != 5'd0 && valid_q[li] && we_q[li] && rd_q[li] == src[s]) begin
                    hz[s]  = 1'b1;
                    ent[s] = li;
                    cmp[s] = done_q[li];
                    res[s] = result_q[li];
                end
            end
`ifdef ROB_BYPASS_EN
            for (int p = 0; p < WB_PORTS; p++) begin
                if (hz[s] && bus.wb_valid_i[p] && wb_idx[p] == ent[s]) begin
                    cmp[s] = 1'b1;
                    res[s] = bus.wb_result_i[p*32 +: 32];
                end
            end
`else
`endif
            if (!cmp[s]) res[s] = '0;
        end
    end

    assign bus.hazard_rs1_o    = hz[0];
    assign bus.hazard_rs2_o    = hz[1];
    assign bus.entry_rs1_o     = ent[0];
    assign bus.entry_rs2_o     = ent[1];
    assign bus.completed_rs1_o = cmp[0];
    assign bus.completed_rs2_o = cmp[1];
    assign bus.result_rs1_o    = res[0];
    assign bus.result_rs2_o    = res[1];
endmodule

// File: tb/tb_rob_wide.sv
// Directed bench for rob_wide: queue-based reference model checked every cycle plus literal expectations.
module tb_rob_wide;
    localparam int DEPTH = 8;
    localparam int CW    = 2;
    localparam int WBP   = 1;
    localparam int IDX_W = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    rob_wide_if #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW), .WB_PORTS(WBP)) bus ();
    rob_wide #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW), .WB_PORTS(WBP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] pc, instr, result, npc;
        logic [4:0]  rd;
        logic        we, done, taken;
    } ent_t;
    ent_t rob[$];
    int   head = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_ncommit(output logic fl, output logic [31:0] fpc);
        int n = 0;
        fl  = 1'b0;
        fpc = '0;
        for (int i = 0; i < CW && i < rob.size(); i++) begin
            if (!rob[i].done) break;
            n++;
            if (rob[i].taken) begin
                fl  = 1'b1;
                fpc = rob[i].npc;
                break;
            end
        end
        return n;
    endfunction

    function automatic void m_lookup(input logic [4:0] a, output logic hz, output logic [31:0] ent,
                                     output logic cmp, output logic [31:0] res);
        hz = 1'b0; ent = '0; cmp = 1'b0; res = '0;
        if (a != 5'd0) begin
            for (int i = rob.size() - 1; i >= 0; i--) begin
                if (rob[i].we && rob[i].rd == a) begin
                    hz  = 1'b1;
                    ent = (head + i) % DEPTH;
                    cmp = rob[i].done;
                    res = rob[i].result;
                    break;
                end
            end
        end
`ifdef ROB_BYPASS_EN
        if (hz && bus.wb_valid_i[0] && 32'(bus.wb_idx_i) == ent) begin
            cmp = 1'b1;
            res = bus.wb_result_i;
        end
`endif
        if (!cmp) res = '0;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rob.delete();
            head = 0;
        end else begin
            int n, sz, off;
            logic fl;
            logic [31:0] fpc;
            ent_t e;
            n  = m_ncommit(fl, fpc);
            sz = rob.size();
            if (fl) begin
                rob.delete();
                head = 0;
            end else begin
                for (int p = 0; p < WBP; p++) begin
                    if (bus.wb_valid_i[p]) begin
                        off = (int'(bus.wb_idx_i[p*IDX_W +: IDX_W]) - head + DEPTH) % DEPTH;
                        if (off < sz) begin
                            rob[off].done   = 1'b1;
                            rob[off].result = bus.wb_result_i[p*32 +: 32];
                            rob[off].taken  = bus.wb_branch_taken_i[p];
                            rob[off].npc    = bus.wb_new_pc_i[p*32 +: 32];
                        end
                    end
                end
                for (int i = 0; i < n; i++) void'(rob.pop_front());
                head = (head + n) % DEPTH;
                if (bus.alloc_valid_i && sz < DEPTH) begin
                    e.pc = bus.alloc_pc_i; e.instr = bus.alloc_instr_i; e.rd = bus.alloc_rd_i;
                    e.we = bus.alloc_we_i; e.done = 1'b0; e.taken = 1'b0; e.result = '0; e.npc = '0;
                    rob.push_back(e);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            int n;
            logic fl, hz, cmp;
            logic [31:0] fpc, ent, res;
            logic [CW-1:0] cv;
            n  = m_ncommit(fl, fpc);
            cv = '0;
            for (int i = 0; i < n; i++) cv[i] = 1'b1;
            chk("full", 32'(bus.full_o), 32'(rob.size() == DEPTH));
            chk("empty", 32'(bus.empty_o), 32'(rob.size() == 0));
            chk("alloc_idx", 32'(bus.alloc_idx_o), (head + rob.size()) % DEPTH);
            chk("commit_valid", 32'(bus.commit_valid_o), 32'(cv));
            for (int i = 0; i < n; i++) begin
                chk("commit_pc", bus.commit_pc_o[i*32 +: 32], rob[i].pc);
                chk("commit_instr", bus.commit_instr_o[i*32 +: 32], rob[i].instr);
                chk("commit_result", bus.commit_result_o[i*32 +: 32], rob[i].result);
                chk("commit_rd", 32'(bus.commit_rd_o[i*5 +: 5]), 32'(rob[i].rd));
                chk("commit_we", 32'(bus.commit_we_o[i]), 32'(rob[i].we));
            end
            chk("flush", 32'(bus.flush_o), 32'(fl));
            if (fl) chk("flush_pc", bus.flush_pc_o, fpc);
            m_lookup(bus.rs1_addr_i, hz, ent, cmp, res);
            chk("hazard_rs1", 32'(bus.hazard_rs1_o), 32'(hz));
            chk("entry_rs1", 32'(bus.entry_rs1_o), ent);
            chk("completed_rs1", 32'(bus.completed_rs1_o), 32'(cmp));
            chk("result_rs1", bus.result_rs1_o, res);
            m_lookup(bus.rs2_addr_i, hz, ent, cmp, res);
            chk("hazard_rs2", 32'(bus.hazard_rs2_o), 32'(hz));
            chk("entry_rs2", 32'(bus.entry_rs2_o), ent);
            chk("completed_rs2", 32'(bus.completed_rs2_o), 32'(cmp));
            chk("result_rs2", bus.result_rs2_o, res);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        bus.alloc_valid_i = 1'b0;
        bus.wb_valid_i    = '0;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we);
        bus.alloc_valid_i = 1'b1;
        bus.alloc_pc_i    = pc;
        bus.alloc_instr_i = pc ^ 32'h0000_0013;
        bus.alloc_rd_i    = rd;
        bus.alloc_we_i    = we;
        tick();
    endtask

    task automatic set_wb(input int idx, input logic [31:0] res, input logic tk, input logic [31:0] npc);
        bus.wb_valid_i        = 1'b1;
        bus.wb_idx_i          = IDX_W'(idx);
        bus.wb_result_i       = res;
        bus.wb_branch_taken_i = tk;
        bus.wb_new_pc_i       = npc;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.rs1_addr_i = '0;
        bus.rs2_addr_i = '0;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        bus.alloc_valid_i = 1'b0; bus.alloc_pc_i = '0; bus.alloc_instr_i = '0;
        bus.alloc_rd_i = '0; bus.alloc_we_i = 1'b0;
        bus.wb_valid_i = '0; bus.wb_idx_i = '0; bus.wb_result_i = '0;
        bus.wb_branch_taken_i = '0; bus.wb_new_pc_i = '0;
        bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
        #1;
        rst_i  = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_empty", 32'(bus.empty_o), 32'd1);
        chk("rst_full", 32'(bus.full_o), 32'd0);
        chk("rst_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);
        chk("rst_commit_valid", 32'(bus.commit_valid_o), 32'd0);
        chk("rst_flush", 32'(bus.flush_o), 32'd0);
        chk("rst_hazard", 32'(bus.hazard_rs1_o), 32'd0);
        chk("rst_result", bus.result_rs1_o, 32'd0);
        rst_i = 1'b0;

        // Reset with five entries in flight
        for (int i = 0; i < 5; i++) do_alloc(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1);
        set_wb(0, 32'h77, 1'b0, '0);
        tick();
        chk("mid_alloc_idx", 32'(bus.alloc_idx_o), 32'd5);
        rst_i = 1'b1;
        #1;
        chk("async_rst_empty", 32'(bus.empty_o), 32'd1);
        tick();
        chk("mid_rst_empty", 32'(bus.empty_o), 32'd1);
        chk("mid_rst_commit", 32'(bus.commit_valid_o), 32'd0);
        chk("mid_rst_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);
        rst_i = 1'b0;

        // Fill, overflow drop, dual retire
        for (int i = 0; i < 8; i++) do_alloc(32'h200 + 32'(4 * i), 5'(i + 1), 1'b1);
        chk("fill_full", 32'(bus.full_o), 32'd1);
        chk("fill_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);
        do_alloc(32'h300, 5'd9, 1'b1);
        chk("drop_full", 32'(bus.full_o), 32'd1);
        set_wb(1, 32'h11, 1'b0, '0);
        tick();
        chk("wb1_commit", 32'(bus.commit_valid_o), 32'd0);
        set_wb(0, 32'h10, 1'b0, '0);
        tick();
        chk("dual_commit", 32'(bus.commit_valid_o), 32'd3);
        chk("dual_full_still", 32'(bus.full_o), 32'd1);
        chk("dual_pc0", bus.commit_pc_o[31:0], 32'h200);
        chk("dual_pc1", bus.commit_pc_o[63:32], 32'h204);
        chk("dual_res1", bus.commit_result_o[63:32], 32'h11);
        tick();
        chk("after_full", 32'(bus.full_o), 32'd0);
        do_reset();

        // Youngest-producer lookup
        do_alloc(32'h10, 5'd5, 1'b1);
        do_alloc(32'h14, 5'd6, 1'b1);
        do_alloc(32'h18, 5'd5, 1'b1);
        bus.rs1_addr_i = 5'd5;
        bus.rs2_addr_i = 5'd6;
        #1;
        chk("lk_hazard1", 32'(bus.hazard_rs1_o), 32'd1);
        chk("lk_entry1", 32'(bus.entry_rs1_o), 32'd2);
        chk("lk_completed1", 32'(bus.completed_rs1_o), 32'd0);
        chk("lk_entry2", 32'(bus.entry_rs2_o), 32'd1);
        set_wb(2, 32'hAB, 1'b0, '0);
        #1;
`ifdef ROB_BYPASS_EN
        chk("lk_byp_completed1", 32'(bus.completed_rs1_o), 32'd1);
        chk("lk_byp_result1", bus.result_rs1_o, 32'hAB);
`else
        chk("lk_nobyp_completed1", 32'(bus.completed_rs1_o), 32'd0);
        chk("lk_nobyp_result1", bus.result_rs1_o, 32'd0);
`endif
        tick();
        chk("lk_completed1_next", 32'(bus.completed_rs1_o), 32'd1);
        chk("lk_result1_next", bus.result_rs1_o, 32'hAB);
        chk("lk_no_commit", 32'(bus.commit_valid_o), 32'd0);
        do_reset();

        // Same-cycle writeback to the rs2 producer
        do_alloc(32'h20, 5'd1, 1'b1);
        do_alloc(32'h24, 5'd2, 1'b1);
        do_alloc(32'h28, 5'd6, 1'b1);
        bus.rs2_addr_i = 5'd6;
        set_wb(2, 32'h55, 1'b0, '0);
        #1;
`ifdef ROB_BYPASS_EN
        chk("byp_completed2", 32'(bus.completed_rs2_o), 32'd1);
        chk("byp_result2", bus.result_rs2_o, 32'h55);
`else
        chk("nobyp_completed2", 32'(bus.completed_rs2_o), 32'd0);
        chk("nobyp_result2", bus.result_rs2_o, 32'd0);
`endif
        tick();
        chk("wb_completed2_next", 32'(bus.completed_rs2_o), 32'd1);
        chk("wb_result2_next", bus.result_rs2_o, 32'h55);
        do_reset();

        // Taken branch flush
        do_alloc(32'h40, 5'd7, 1'b1);
        do_alloc(32'h44, 5'd8, 1'b0);
        do_alloc(32'h48, 5'd9, 1'b1);
        set_wb(2, 32'h3, 1'b0, '0);
        tick();
        set_wb(1, 32'h2, 1'b1, 32'h200);
        tick();
        chk("br_wait_commit", 32'(bus.commit_valid_o), 32'd0);
        set_wb(0, 32'h1, 1'b0, '0);
        tick();
        chk("br_commit", 32'(bus.commit_valid_o), 32'd3);
        chk("br_flush", 32'(bus.flush_o), 32'd1);
        chk("br_flush_pc", bus.flush_pc_o, 32'h200);
        chk("br_pc0", bus.commit_pc_o[31:0], 32'h40);
        chk("br_pc1", bus.commit_pc_o[63:32], 32'h44);
        bus.alloc_valid_i = 1'b1;
        bus.alloc_pc_i    = 32'h4C;
        tick();
        chk("br_empty", 32'(bus.empty_o), 32'd1);
        chk("br_no_commit", 32'(bus.commit_valid_o), 32'd0);
        chk("br_alloc_idx", 32'(bus.alloc_idx_o), 32'd0);

        // Head wrap from 7 to 1
        for (int i = 0; i < 7; i++) do_alloc(32'h500 + 32'(4 * i), 5'd10, 1'b1);
        for (int i = 0; i < 7; i++) begin
            set_wb(i, 32'h900 + 32'(i), 1'b0, '0);
            tick();
        end
        tick();
        tick();
        chk("wrap_empty", 32'(bus.empty_o), 32'd1);
        chk("wrap_alloc_idx7", 32'(bus.alloc_idx_o), 32'd7);
        do_alloc(32'h600, 5'd11, 1'b1);
        chk("wrap_alloc_idx0", 32'(bus.alloc_idx_o), 32'd0);
        do_alloc(32'h604, 5'd12, 1'b1);
        set_wb(0, 32'hB0, 1'b0, '0);
        tick();
        chk("wrap_wait", 32'(bus.commit_valid_o), 32'd0);
        set_wb(7, 32'hB7, 1'b0, '0);
        tick();
        chk("wrap_commit", 32'(bus.commit_valid_o), 32'd3);
        chk("wrap_pc0", bus.commit_pc_o[31:0], 32'h600);
        chk("wrap_pc1", bus.commit_pc_o[63:32], 32'h604);
        chk("wrap_res0", bus.commit_result_o[31:0], 32'hB7);
        tick();
        chk("wrap_after_empty", 32'(bus.empty_o), 32'd1);
        chk("wrap_head1", 32'(bus.alloc_idx_o), 32'd1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach end (checks %0d)", checks);
        $fatal(1, "timeout");
    end
endmodule
